zjh_gate_tester: RTL and testbench

ZJH_GATE_TESTER -- requirements
Module: zjh_gate_tester

---
 rtl/zjh_gate_pkg.sv | 35 +++
 rtl/zjh_gate_ref.sv | 13 +
 rtl/zjh_gate_tester.sv | 104 ++++++++++
 tb/tb_zjh_gate_tester.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zjh_gate_pkg.sv
// Shared definitions for the two-input gate tester: FSM states, the bit
// positions of each gate output on y_in, and the golden gate model.
package zjh_gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int Y_AND  = 0;
  localparam int Y_NAND = 1;
  localparam int Y_OR   = 2;
  localparam int Y_NOR  = 3;
  localparam int Y_XOR  = 4;
  localparam int Y_NOTA = 5;

  localparam int NUM_Y   = 6;
  localparam int NUM_VEC = 4;

  // Expected outputs of a correct gate board for inputs (a, b)
  function automatic logic [NUM_Y-1:0] golden(input logic a, input logic b);
    logic [NUM_Y-1:0] y;
    y         = '0;
    y[Y_AND]  = a & b;
    y[Y_NAND] = ~(a & b);
    y[Y_OR]   = a | b;
    y[Y_NOR]  = ~(a | b);
    y[Y_XOR]  = a ^ b;
    y[Y_NOTA] = ~a;
    return y;
  endfunction

endpackage

// File: rtl/zjh_gate_ref.sv
// Combinational reference model: wraps the golden function so the tester
// and the testbench use one definition of the correct gate behaviour.
module zjh_gate_ref
  import zjh_gate_pkg::*;
(
  input  logic             a,
  input  logic             b,
  output logic [NUM_Y-1:0] y_exp
);

  assign y_exp = golden(a, b);

endmodule

// File: rtl/zjh_gate_tester.sv
// Truth-table sweeper for a six-output two-input gate board. Drives the four
// (A,B) vectors in order, lets each settle, compares the board outputs with
// the golden model and accumulates sticky per-output and per-vector errors.
module zjh_gate_tester
  import zjh_gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NUM_Y-1:0]   y_in,
  output logic               gate_a,
  output logic               gate_b,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_Y-1:0]   err_mask,
  output logic [NUM_VEC-1:0] err_vec
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e           state;
  logic [1:0]       vec_idx;
  logic [3:0]       settle_cnt;
  logic [NUM_Y-1:0] y_exp;
  logic [NUM_Y-1:0] y_diff;

  // Expected values come from the registered gate drive, so they always
  // describe the vector the board is actually seeing.
  zjh_gate_ref u_ref (
    .a     (gate_a),
    .b     (gate_b),
    .y_exp (y_exp)
  );

  assign y_diff = y_in ^ y_exp;

  // Sweep sequencer: settle, sample, advance vector, and report at the end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vec_idx    <= 2'd0;
      settle_cnt <= 4'd0;
      gate_a     <= 1'b0;
      gate_b     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_mask   <= '0;
      err_vec    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            vec_idx    <= 2'd0;
            gate_a     <= 1'b0;
            gate_b     <= 1'b0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_mask   <= '0;
            err_vec    <= '0;
            settle_cnt <= 4'd0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          err_mask <= err_mask | y_diff;
          if (|y_diff) begin
            err_vec[vec_idx] <= 1'b1;
          end
          if (vec_idx != 2'd3) begin
            vec_idx           <= vec_idx + 2'd1;
            {gate_a, gate_b}  <= vec_idx + 2'd1;
            settle_cnt        <= 4'd0;
            state             <= ST_SETTLE;
          end else begin
            // The final sample is folded into pass here so that pass is
            // already valid in the cycle that done is high.
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= ((err_mask | y_diff) == '0);
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zjh_gate_tester.sv
// Self-checking bench for zjh_gate_tester. A behavioural gate board (with
// selectable faults) feeds the tester; each sweep pushes its expected result
// onto a scoreboard that is popped when done is seen.
module tb_zjh_gate_tester;

  typedef struct {
    int         lat;
    logic       pass;
    logic [5:0] mask;
    logic [3:0] vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start1;
  logic [5:0] y0, y1;
  logic [1:0] fault_mode;

  logic gate_a0, gate_b0, busy0, done0, pass0;
  logic [5:0] err_mask0;
  logic [3:0] err_vec0;
  logic gate_a1, gate_b1, busy1, done1, pass1;
  logic [5:0] err_mask1;
  logic [3:0] err_vec1;

  logic ref_a, ref_b;
  logic [5:0] ref_y;

  int sel_q;
  logic s_a, s_b, s_busy, s_done, s_pass;
  logic [5:0] s_mask;
  logic [3:0] s_vec;

  int checks = 0;
  int passes = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  zjh_gate_tester #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start0),
    .y_in     (y0),
    .gate_a   (gate_a0),
    .gate_b   (gate_b0),
    .busy     (busy0),
    .done     (done0),
    .pass     (pass0),
    .err_mask (err_mask0),
    .err_vec  (err_vec0)
  );

  zjh_gate_tester #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .y_in     (y1),
    .gate_a   (gate_a1),
    .gate_b   (gate_b1),
    .busy     (busy1),
    .done     (done1),
    .pass     (pass1),
    .err_mask (err_mask1),
    .err_vec  (err_vec1)
  );

  zjh_gate_ref u_ref (
    .a     (ref_a),
    .b     (ref_b),
    .y_exp (ref_y)
  );

  assign s_a    = (sel_q == 0) ? gate_a0   : gate_a1;
  assign s_b    = (sel_q == 0) ? gate_b0   : gate_b1;
  assign s_busy = (sel_q == 0) ? busy0     : busy1;
  assign s_done = (sel_q == 0) ? done0     : done1;
  assign s_pass = (sel_q == 0) ? pass0     : pass1;
  assign s_mask = (sel_q == 0) ? err_mask0 : err_mask1;
  assign s_vec  = (sel_q == 0) ? err_vec0  : err_vec1;

  // Independent truth table of a good board, bits 5..0 = NOTA XOR NOR OR NAND AND
  function automatic logic [5:0] bench_truth(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 6'b101010;
      2'b01:   return 6'b110110;
      2'b10:   return 6'b010110;
      default: return 6'b000101;
    endcase
  endfunction

  // Board model with optional faults: 1 = Y5 stuck at 0, 2 = Y6 wired to ~B
  function automatic logic [5:0] board(input logic a, input logic b, input logic [1:0] mode);
    logic [5:0] y;
    y = bench_truth(a, b);
    if (mode == 2'd1) y[4] = 1'b0;
    if (mode == 2'd2) y[5] = ~b;
    return y;
  endfunction

  // Zero-delay board on the SETTLE_CYCLES=2 tester
  always_comb y0 = board(gate_a0, gate_b0, fault_mode);

  // Board with one cycle of output delay on the SETTLE_CYCLES=1 tester
  always @(posedge clk) y1 <= board(gate_a1, gate_b1, fault_mode);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Start one sweep and push its expected outcome onto the scoreboard
  task automatic applyStimulus(input int sel, input logic [1:0] mode, input int settle);
    exp_t e;
    e.mask = '0;
    e.vec  = '0;
    for (int v = 0; v < 4; v++) begin
      logic [1:0] vv;
      logic [5:0] d;
      vv = 2'(v);
      d  = bench_truth(vv[1], vv[0]) ^ board(vv[1], vv[0], mode);
      e.mask = e.mask | d;
      if (d != 6'd0) e.vec[vv] = 1'b1;
    end
    e.lat  = 4 * (settle + 1);
    e.pass = (e.mask == 6'd0);
    sb.push_back(e);
    @(negedge clk);
    fault_mode = mode;
    sel_q = sel;
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Follow the sweep edge by edge, then pop and compare at done
  task automatic collectResult(input int settle);
    exp_t e;
    int k;
    int vi;
    bit seen;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 64) begin
      @(posedge clk);
      #1;
      k++;
      if (s_done) seen = 1'b1;
      else begin
        vi = k / (settle + 1);
        if (vi > 3) vi = 3;
        checkOutput("sweep_busy_gates", {s_busy, s_a, s_b}, {1'b1, 2'(vi)});
      end
    end
    if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (seen) begin
        checkOutput("done_latency", k, e.lat);
        checkOutput("pass", s_pass, e.pass);
        checkOutput("err_mask", s_mask, e.mask);
        checkOutput("err_vec", s_vec, e.vec);
        checkOutput("end_busy_gates", {s_busy, s_a, s_b}, 3'b011);
      end
    end
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", s_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d1, d2, cyc;
    rst_n = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    fault_mode = 2'd0;
    sel_q = 0;
    ref_a = 1'b0;
    ref_b = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_dut0", {gate_a0, gate_b0, busy0, done0, pass0, err_mask0, err_vec0}, 15'd0);
    checkOutput("reset_dut1", {gate_a1, gate_b1, busy1, done1, pass1, err_mask1, err_vec1}, 15'd0);

    // start on the same edge as reset must be dropped
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("start_in_reset", busy0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      ref_a = ab[1];
      ref_b = ab[0];
      #1;
      checkOutput("golden_ref", ref_y, bench_truth(ab[1], ab[0]));
    end

    applyStimulus(0, 2'd0, 2);
    collectResult(2);

    applyStimulus(0, 2'd1, 2);
    collectResult(2);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("y5_hold_pass", pass0, 1'b0);
    checkOutput("y5_hold_mask", err_mask0, 6'b010000);
    checkOutput("y5_hold_vec", err_vec0, 4'b0110);
    checkOutput("y5_hold_gates", {gate_a0, gate_b0}, 2'b11);

    applyStimulus(0, 2'd2, 2);
    collectResult(2);
    checkOutput("y6_mask", err_mask0, 6'b100000);
    checkOutput("y6_vec", err_vec0, 4'b0110);

    // start held high: one sweep per IDLE visit, restart on first IDLE edge
    @(negedge clk);
    fault_mode = 2'd0;
    start0 = 1'b1;
    d1 = -1;
    d2 = -1;
    cyc = 0;
    while (d2 < 0 && cyc < 80) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done0) begin
        if (d1 < 0) d1 = cyc;
        else d2 = cyc;
      end
    end
    start0 = 1'b0;
    checkOutput("held_first_done", d1, 13);
    // 14 edges between rising edges of done = 13 low cycles between pulses
    checkOutput("held_done_spacing", d2 - d1, 14);
    checkOutput("held_pass", pass0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("held_no_queue", busy0, 1'b0);

    // reset during the settle of vector 2
    @(negedge clk);
    fault_mode = 2'd1;
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checkOutput("midrst_pre_state", {busy0, gate_a0, gate_b0}, 3'b110);
    checkOutput("midrst_pre_mask", err_mask0, 6'b010000);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_outputs", {gate_a0, gate_b0, busy0, done0, pass0, err_mask0, err_vec0}, 15'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 2'd0, 2);
    collectResult(2);

    // SETTLE_CYCLES=1 against a board with one cycle of output delay
    applyStimulus(1, 2'd0, 1);
    collectResult(1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
